// File: rtl/leaf_out_sched.sv
// Leaf output scheduler: round-robin merge of user streams into
// credit-limited BFT packets with per-port destination and address.
module leaf_out_sched #(
  parameter int PACKET_BITS   = 49,
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_LEAF_BITS = 5,
  parameter int NUM_PORT_BITS = 4,
  parameter int NUM_ADDR_BITS = 7,
  parameter int NUM_OUT_PORTS = 2
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  enable,
  input  logic                                  cfg_we,
  input  logic [NUM_PORT_BITS-1:0]              cfg_port,
  input  logic [NUM_LEAF_BITS+NUM_PORT_BITS-1:0] cfg_dest,
  input  logic                                  credit_vld,
  input  logic [NUM_PORT_BITS-1:0]              credit_port,
  input  logic [NUM_ADDR_BITS:0]                credit_amt,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_user,
  input  logic [NUM_OUT_PORTS-1:0]              vld_user,
  output logic [NUM_OUT_PORTS-1:0]              ack_user,
  input  logic                                  pkt_ready,
  output logic [PACKET_BITS-1:0]                dout_pkt,
  output logic                                  credit_err
);

  localparam int DW = NUM_LEAF_BITS + NUM_PORT_BITS;
  localparam int CW = NUM_ADDR_BITS + 1;
  localparam int GW = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
  localparam logic [CW:0] CMAX = {2'b01, {NUM_ADDR_BITS{1'b0}}};
  localparam logic [CW:0] ONE  = {{CW{1'b0}}, 1'b1};

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t state_q, state_d;
  logic   run;

  logic [NUM_OUT_PORTS-1:0] cfg_ok_q, cfg_ok_d;
  logic [DW-1:0]            dest_q   [NUM_OUT_PORTS];
  logic [DW-1:0]            dest_d   [NUM_OUT_PORTS];
  logic [CW-1:0]            credit_q [NUM_OUT_PORTS];
  logic [CW-1:0]            credit_d [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] addr_q   [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] addr_d   [NUM_OUT_PORTS];

  logic [GW-1:0]            last_q, last_d;
  logic [PACKET_BITS-1:0]   dout_q, dout_d;
  logic                     err_q, err_d;

  logic [NUM_OUT_PORTS-1:0] elig;
  logic                     gnt_vld;
  logic [GW-1:0]            gnt_idx;
  logic [PAYLOAD_BITS-1:0]  gnt_word;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (enable)  state_d = S_RUN;
      S_RUN:   if (!enable) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    run = (state_q == S_RUN);
  end

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      elig[i] = run && !reset && pkt_ready && vld_user[i] &&
                cfg_ok_q[i] && (credit_q[i] != '0);
    end
  end

  // Round-robin search starting just after the last winner
  always_comb begin : rr_search
    int            pos;
    logic [GW-1:0] cand;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    pos     = 0;
    cand    = '0;
    for (int k = 1; k <= NUM_OUT_PORTS; k++) begin
      pos  = (int'(last_q) + k) % NUM_OUT_PORTS;
      cand = GW'(pos);
      if (!gnt_vld && elig[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    ack_user = '0;
    gnt_word = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      if (gnt_vld && gnt_idx == GW'(i)) begin
        ack_user[i] = 1'b1;
        gnt_word    = din_user[i*PAYLOAD_BITS +: PAYLOAD_BITS];
      end
    end
  end

  always_comb begin : port_next
    logic [CW:0] csum;
    csum     = '0;
    cfg_ok_d = cfg_ok_q;
    err_d    = err_q;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      dest_d[i] = dest_q[i];
      addr_d[i] = addr_q[i];
      if (cfg_we && int'(cfg_port) == i) begin
        cfg_ok_d[i] = 1'b1;
        dest_d[i]   = cfg_dest;
      end
      if (ack_user[i]) addr_d[i] = addr_q[i] + NUM_ADDR_BITS'(1);
      csum = {1'b0, credit_q[i]};
      if (ack_user[i]) csum = csum - ONE;
      if (credit_vld && int'(credit_port) == i)
        csum = csum + {1'b0, credit_amt};
      if (csum > CMAX) begin
        credit_d[i] = CMAX[CW-1:0];
        err_d       = 1'b1;
      end else begin
        credit_d[i] = csum[CW-1:0];
      end
    end
  end

  always_comb begin
    last_d = last_q;
    dout_d = '0;
    if (gnt_vld) begin
      last_d = gnt_idx;
      dout_d = {1'b1, dest_q[gnt_idx], addr_q[gnt_idx], gnt_word};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_ok_q <= '0;
      last_q   <= GW'(NUM_OUT_PORTS - 1);
      dout_q   <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        dest_q[i]   <= '0;
        credit_q[i] <= CMAX[CW-1:0];
        addr_q[i]   <= '0;
      end
    end else begin
      cfg_ok_q <= cfg_ok_d;
      last_q   <= last_d;
      dout_q   <= dout_d;
      err_q    <= err_d;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        dest_q[i]   <= dest_d[i];
        credit_q[i] <= credit_d[i];
        addr_q[i]   <= addr_d[i];
      end
    end
  end

  assign dout_pkt   = dout_q;
  assign credit_err = err_q;

endmodule

// File: tb/tb_leaf_out_sched.sv
// Directed bench for leaf_out_sched: grants, packets, credits,
// address wrap, config timing and reset behaviour.
module tb_leaf_out_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        cfg_we;
  logic [3:0]  cfg_port;
  logic [8:0]  cfg_dest;
  logic        credit_vld;
  logic [3:0]  credit_port;
  logic [7:0]  credit_amt;
  logic [63:0] din_user;
  logic [1:0]  vld_user;
  logic [1:0]  ack_user;
  logic        pkt_ready;
  logic [48:0] dout_pkt;
  logic        credit_err;

  int n_chk = 0;
  int n_err = 0;

  leaf_out_sched dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .cfg_we     (cfg_we),
    .cfg_port   (cfg_port),
    .cfg_dest   (cfg_dest),
    .credit_vld (credit_vld),
    .credit_port(credit_port),
    .credit_amt (credit_amt),
    .din_user   (din_user),
    .vld_user   (vld_user),
    .ack_user   (ack_user),
    .pkt_ready  (pkt_ready),
    .dout_pkt   (dout_pkt),
    .credit_err (credit_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [48:0] pkt(input logic [4:0] l,
                                      input logic [3:0] p,
                                      input logic [6:0] a,
                                      input logic [31:0] w);
    return {1'b1, l, p, a, w};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic cfg(input logic [3:0] p, input logic [8:0] d);
    cfg_we   = 1'b1;
    cfg_port = p;
    cfg_dest = d;
    tick();
    cfg_we   = 1'b0;
  endtask

  logic [1:0]  exp_ack [4];
  logic [48:0] exp_pkt [4];
  logic [6:0]  got_addr [4];
  logic [6:0]  exp_addr [4];
  int          n;

  initial begin
    enable = 0; cfg_we = 0; cfg_port = 0; cfg_dest = 0;
    credit_vld = 0; credit_port = 0; credit_amt = 0;
    din_user = 0; vld_user = 0; pkt_ready = 1; reset = 1;

    // ---- phase A: reset values, single port, gating ----
    do_reset();
    check("rst_dout", 64'(dout_pkt), 0);
    check("rst_ack", 64'(ack_user), 0);
    check("rst_err", 64'(credit_err), 0);

    enable = 1; vld_user = 2'b11;
    tick();
    #1 check("unconfig_ack", 64'(ack_user), 0);
    tick();
    check("unconfig_dout", 64'(dout_pkt), 0);

    cfg(4'd0, {5'd3, 4'd2});
    vld_user = 2'b01;
    din_user[31:0] = 32'hA5A5A5A5;
    #1 check("a_ack0", 64'(ack_user), 64'b01);
    tick();
    check("a_pkt0", 64'(dout_pkt),
          64'(pkt(5'd3, 4'd2, 7'd0, 32'hA5A5A5A5)));
    din_user[31:0] = 32'h5A5A5A5A;
    #1 check("a_ack1", 64'(ack_user), 64'b01);
    tick();
    check("a_pkt1", 64'(dout_pkt),
          64'(pkt(5'd3, 4'd2, 7'd1, 32'h5A5A5A5A)));

    pkt_ready = 0;
    #1 check("nordy_ack", 64'(ack_user), 0);
    tick();
    check("nordy_dout", 64'(dout_pkt), 0);
    pkt_ready = 1;

    enable = 0;
    din_user[31:0] = 32'h00000022;
    #1 check("en_drop_ack", 64'(ack_user), 64'b01);
    tick();
    check("en_drop_pkt", 64'(dout_pkt),
          64'(pkt(5'd3, 4'd2, 7'd2, 32'h22)));
    #1 check("en_off_ack", 64'(ack_user), 0);
    tick();
    check("en_off_dout", 64'(dout_pkt), 0);
    enable = 1;
    #1 check("en_wait_ack", 64'(ack_user), 0);
    tick();
    din_user[31:0] = 32'h00000033;
    #1 check("en_resume_ack", 64'(ack_user), 64'b01);
    tick();
    check("en_resume_pkt", 64'(dout_pkt),
          64'(pkt(5'd3, 4'd2, 7'd3, 32'h33)));
    vld_user = 0;

    // ---- phase B: round robin, cfg/grant overlap, reset discard ----
    enable = 0;
    do_reset();
    cfg(4'd0, {5'd3, 4'd2});
    cfg(4'd1, {5'd7, 4'd9});
    enable = 1;
    tick();
    din_user = {32'hBEEF0001, 32'hC0DE0000};
    vld_user = 2'b11;
    exp_ack[0] = 2'b01; exp_ack[1] = 2'b10;
    exp_ack[2] = 2'b01; exp_ack[3] = 2'b10;
    exp_pkt[0] = pkt(5'd3, 4'd2, 7'd0, 32'hC0DE0000);
    exp_pkt[1] = pkt(5'd7, 4'd9, 7'd0, 32'hBEEF0001);
    exp_pkt[2] = pkt(5'd3, 4'd2, 7'd1, 32'hC0DE0000);
    exp_pkt[3] = pkt(5'd7, 4'd9, 7'd1, 32'hBEEF0001);
    for (int i = 0; i < 4; i++) begin
      #1 check($sformatf("rr_ack%0d", i), 64'(ack_user), 64'(exp_ack[i]));
      tick();
      check($sformatf("rr_pkt%0d", i), 64'(dout_pkt), 64'(exp_pkt[i]));
    end

    vld_user = 2'b01;
    cfg_we = 1; cfg_port = 4'd0; cfg_dest = {5'd1, 4'd1};
    #1 check("cfgov_ack", 64'(ack_user), 64'b01);
    tick();
    cfg_we = 0;
    check("cfgov_old", 64'(dout_pkt),
          64'(pkt(5'd3, 4'd2, 7'd2, 32'hC0DE0000)));
    tick();
    check("cfgov_new", 64'(dout_pkt),
          64'(pkt(5'd1, 4'd1, 7'd3, 32'hC0DE0000)));

    reset = 1;
    tick();
    reset = 0;
    check("rst_discard", 64'(dout_pkt), 0);
    tick();
    #1 check("rst_cfg_clr", 64'(ack_user), 0);
    vld_user = 0;

    // ---- phase C: credit exhaustion and return on port 1 ----
    enable = 0;
    do_reset();
    cfg(4'd0, {5'd3, 4'd2});
    cfg(4'd1, {5'd2, 4'd5});
    enable = 1;
    tick();
    din_user = {32'h0000BEAD, 32'h0};
    vld_user = 2'b10;
    n = 0;
    repeat (128) begin
      #1 if (ack_user == 2'b10) n++;
      tick();
    end
    check("cr_sent", 64'(n), 128);
    #1 check("cr_empty_ack", 64'(ack_user), 0);
    tick();
    check("cr_empty_dout", 64'(dout_pkt), 0);
    credit_vld = 1; credit_port = 4'd1; credit_amt = 8'd64;
    tick();
    credit_vld = 0;
    #1 check("cr_resume_ack", 64'(ack_user), 64'b10);
    tick();
    check("cr_resume_pkt", 64'(dout_pkt),
          64'(pkt(5'd2, 4'd5, 7'd0, 32'h0000BEAD)));
    check("cr_no_err", 64'(credit_err), 0);
    vld_user = 0;

    // ---- phase D: port 0 address wrap with steady credit return ----
    credit_vld = 1; credit_port = 4'd0; credit_amt = 8'd1;
    vld_user = 2'b01;
    exp_addr[0] = 7'd126; exp_addr[1] = 7'd127;
    exp_addr[2] = 7'd0;   exp_addr[3] = 7'd1;
    n = 0;
    for (int i = 0; i < 130; i++) begin
      din_user[31:0] = 32'(i);
      #1 if (ack_user == 2'b01) n++;
      tick();
      if (i >= 126) got_addr[i-126] = dout_pkt[38:32];
    end
    credit_vld = 0;
    vld_user = 0;
    check("wrap_sent", 64'(n), 130);
    for (int i = 0; i < 4; i++)
      check($sformatf("wrap_addr%0d", i),
            64'(got_addr[i]), 64'(exp_addr[i]));
    check("wrap_no_err", 64'(credit_err), 0);

    // ---- phase E: overflow clamp and sticky error ----
    credit_vld = 1; credit_port = 4'd3; credit_amt = 8'd200;
    tick();
    credit_vld = 0;
    check("ovf_bad_port", 64'(credit_err), 0);
    credit_vld = 1; credit_port = 4'd0; credit_amt = 8'd1;
    tick();
    credit_vld = 0;
    check("ovf_set", 64'(credit_err), 1);
    repeat (3) tick();
    check("ovf_sticky", 64'(credit_err), 1);
    vld_user = 2'b01;
    n = 0;
    repeat (129) begin
      #1 if (ack_user == 2'b01) n++;
      tick();
    end
    vld_user = 0;
    check("ovf_clamp", 64'(n), 128);
    do_reset();
    check("ovf_rst_clr", 64'(credit_err), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
